// File: rtl/bus_pkg.sv
// bus_pkg: shared bus constants and destination-ID extraction.
package bus_pkg;
    localparam int PCKG_SZ = 16;
    localparam int ID_W = 8;
    localparam logic [ID_W-1:0] BROADCAST = '1;
    // Packets up to 64 bits; the ID sits in the top ID_W bits of an sz-bit packet.
    function automatic logic [ID_W-1:0] dest_id(input logic [63:0] pkt, input int unsigned sz);
        return ID_W'(pkt >> (sz - ID_W));
    endfunction
endpackage

// File: rtl/fifo_fwft.sv
// fifo_fwft: first-word-fall-through FIFO; a write into a full FIFO is accepted only alongside a read.
module fifo_fwft #(
    parameter int width = 16,
    parameter int depth = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [width-1:0] wr_data,
    input  logic             rd_en,
    output logic [width-1:0] rd_data,
    output logic             valid,
    output logic             full
);
    localparam int AW = $clog2(depth);
    localparam logic [AW:0] full_cnt = (AW+1)'(depth);
    logic [width-1:0] mem_q [depth];
    logic [width-1:0] mem_d [depth];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0] cnt_q, cnt_d;
    logic do_rd, do_wr;
    assign valid = cnt_q != '0;
    assign full = cnt_q == full_cnt;
    assign rd_data = valid ? mem_q[rptr_q] : '0;
    always_comb begin
        do_rd = rd_en && valid;
        do_wr = wr_en && (!full || do_rd);
        mem_d = mem_q;
        if (do_wr) mem_d[wptr_q] = wr_data;
        wptr_d = do_wr ? wptr_q + 1'b1 : wptr_q;
        rptr_d = do_rd ? rptr_q + 1'b1 : rptr_q;
        cnt_d = cnt_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q <= cnt_d;
        end
    end
    // Storage needs no reset: the zero count hides stale entries.
    always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/bus_dev_fifo.sv
// bus_dev_fifo: bus device with TX/RX FWFT FIFOs, saturating drop counters and misroute detection.
module bus_dev_fifo import bus_pkg::*; #(
    parameter int pckg_sz = PCKG_SZ,
    parameter int depth = 8,
    parameter logic [ID_W-1:0] dev_id = 8'd0,
    parameter logic [ID_W-1:0] broadcast = BROADCAST
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [pckg_sz-1:0] wr_data,
    output logic               tx_full,
    output logic               pndng,
    output logic [pckg_sz-1:0] D_pop,
    input  logic               pop,
    input  logic               push,
    input  logic [pckg_sz-1:0] D_push,
    output logic               rx_valid,
    output logic [pckg_sz-1:0] rx_data,
    input  logic               rx_rd_en,
    output logic [7:0]         tx_drop_cnt,
    output logic [7:0]         rx_drop_cnt,
    output logic [7:0]         misroute_cnt
);
    logic rx_full, tx_drop, rx_drop, misroute;
    logic [ID_W-1:0] id;
    logic [7:0] tx_drop_cnt_q, tx_drop_cnt_d, rx_drop_cnt_q, rx_drop_cnt_d, misroute_cnt_q, misroute_cnt_d;
    fifo_fwft #(.width(pckg_sz), .depth(depth)) u_tx (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(pop),
        .rd_data(D_pop), .valid(pndng), .full(tx_full)
    );
    fifo_fwft #(.width(pckg_sz), .depth(depth)) u_rx (
        .clk(clk), .reset(reset), .wr_en(push), .wr_data(D_push), .rd_en(rx_rd_en),
        .rd_data(rx_data), .valid(rx_valid), .full(rx_full)
    );
    always_comb begin
        id = dest_id(64'(D_push), pckg_sz);
        tx_drop = wr_en && tx_full && !(pop && pndng);
        rx_drop = push && rx_full && !(rx_rd_en && rx_valid);
        misroute = push && id != dev_id && id != broadcast;
        tx_drop_cnt_d = (tx_drop && tx_drop_cnt_q != 8'hFF) ? tx_drop_cnt_q + 8'd1 : tx_drop_cnt_q;
        rx_drop_cnt_d = (rx_drop && rx_drop_cnt_q != 8'hFF) ? rx_drop_cnt_q + 8'd1 : rx_drop_cnt_q;
        misroute_cnt_d = (misroute && misroute_cnt_q != 8'hFF) ? misroute_cnt_q + 8'd1 : misroute_cnt_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_drop_cnt_q <= '0;
            rx_drop_cnt_q <= '0;
            misroute_cnt_q <= '0;
        end else begin
            tx_drop_cnt_q <= tx_drop_cnt_d;
            rx_drop_cnt_q <= rx_drop_cnt_d;
            misroute_cnt_q <= misroute_cnt_d;
        end
    end
    assign tx_drop_cnt = tx_drop_cnt_q;
    assign rx_drop_cnt = rx_drop_cnt_q;
    assign misroute_cnt = misroute_cnt_q;
endmodule

// File: tb/tb_bus_dev_fifo.sv
// tb_bus_dev_fifo: scoreboard bench for bus_dev_fifo with depth 8 and dev_id 2.
module tb_bus_dev_fifo;
    logic clk = 1'b0;
    logic reset, wr_en, pop, push, rx_rd_en;
    logic [15:0] wr_data, D_pop, D_push, rx_data;
    logic tx_full, pndng, rx_valid;
    logic [7:0] tx_drop_cnt, rx_drop_cnt, misroute_cnt;
    int checks = 0, errors = 0;
    logic [15:0] tx_q[$], rx_q[$];
    logic [7:0] m_txd = 0, m_rxd = 0, m_mis = 0;

    always #5 clk = ~clk;

    bus_dev_fifo #(.pckg_sz(16), .depth(8), .dev_id(8'd2)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .tx_full(tx_full),
        .pndng(pndng), .D_pop(D_pop), .pop(pop), .push(push), .D_push(D_push),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_rd_en(rx_rd_en),
        .tx_drop_cnt(tx_drop_cnt), .rx_drop_cnt(rx_drop_cnt), .misroute_cnt(misroute_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] sat(input logic [7:0] x);
        return x == 8'hFF ? x : x + 8'd1;
    endfunction

    task automatic tx_step(input bit w, input logic [15:0] d, input bit p);
        bit pop_ok;
        pop_ok = p && tx_q.size() != 0;
        check("tx_head", D_pop, tx_q.size() != 0 ? tx_q[0] : 16'h0);
        wr_en = w; wr_data = d; pop = p;
        if (pop_ok) void'(tx_q.pop_front());
        if (w && tx_q.size() < 8) tx_q.push_back(d);
        else if (w) m_txd = sat(m_txd);
        tick();
        wr_en = 0; pop = 0;
        check("pndng", pndng, tx_q.size() != 0);
        check("tx_full", tx_full, tx_q.size() == 8);
        check("tx_drop_cnt", tx_drop_cnt, m_txd);
    endtask

    task automatic rx_step(input bit p, input logic [15:0] d, input bit r);
        bit rd_ok;
        rd_ok = r && rx_q.size() != 0;
        check("rx_head", rx_data, rx_q.size() != 0 ? rx_q[0] : 16'h0);
        push = p; D_push = d; rx_rd_en = r;
        if (rd_ok) void'(rx_q.pop_front());
        if (p && d[15:8] != 8'h02 && d[15:8] != 8'hFF) m_mis = sat(m_mis);
        if (p && rx_q.size() < 8) rx_q.push_back(d);
        else if (p) m_rxd = sat(m_rxd);
        tick();
        push = 0; rx_rd_en = 0;
        check("rx_valid", rx_valid, rx_q.size() != 0);
        check("rx_drop_cnt", rx_drop_cnt, m_rxd);
        check("misroute_cnt", misroute_cnt, m_mis);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_pndng"}, pndng, 0);
        check({tag, "_rx_valid"}, rx_valid, 0);
        check({tag, "_tx_full"}, tx_full, 0);
        check({tag, "_D_pop"}, D_pop, 0);
        check({tag, "_rx_data"}, rx_data, 0);
        check({tag, "_counters"}, {tx_drop_cnt, rx_drop_cnt, misroute_cnt}, 0);
    endtask

    initial begin
        reset = 1; wr_en = 0; pop = 0; push = 0; rx_rd_en = 0; wr_data = 0; D_push = 0;
        tick(); tick();
        check_zero("reset");
        reset = 0;
        // Basic write, fall-through, pop back to empty
        tx_step(1, 16'h0155, 0);
        check("D_pop_written", D_pop, 16'h0155);
        tx_step(0, 16'h0, 1);
        check("D_pop_empty", D_pop, 16'h0);
        // Nine writes into depth 8: one refused, head is first packet
        for (int i = 0; i < 9; i++) tx_step(1, 16'h1000 + 16'(i), 0);
        check("tx_drop_one", tx_drop_cnt, 8'd1);
        check("tx_head_first", D_pop, 16'h1000);
        // Full with simultaneous write and pop
        tx_step(1, 16'h2222, 1);
        check("tx_full_stays", tx_full, 1);
        check("tx_drop_same", tx_drop_cnt, 8'd1);
        for (int i = 0; i < 8; i++) tx_step(0, 16'h0, 1);
        // Empty with simultaneous write and pop: pop ignored
        tx_step(1, 16'h3333, 1);
        check("tx_empty_wr_pop", D_pop, 16'h3333);
        tx_step(0, 16'h0, 1);
        tx_step(0, 16'h0, 1);
        // RX ordering and misroute
        rx_step(1, 16'h0211, 0);
        rx_step(1, 16'hFF22, 0);
        rx_step(1, 16'h0333, 0);
        check("misroute_one", misroute_cnt, 8'd1);
        for (int i = 0; i < 3; i++) rx_step(0, 16'h0, 1);
        // Fill RX then overflow past saturation
        for (int i = 0; i < 8; i++) rx_step(1, 16'h0200 + 16'(i), 0);
        for (int i = 0; i < 300; i++) rx_step(1, 16'h02A0 + 16'(i % 16), 0);
        check("rx_drop_sat", rx_drop_cnt, 8'd255);
        rx_step(1, 16'h0299, 1);
        for (int i = 0; i < 9; i++) rx_step(0, 16'h0, 1);
        check("rx_drop_hold", rx_drop_cnt, 8'd255);
        // Reset mid-operation with all strobes active
        for (int i = 0; i < 5; i++) tx_step(1, 16'h0500 + 16'(i), 0);
        for (int i = 0; i < 3; i++) rx_step(1, 16'h0260 + 16'(i), 0);
        reset = 1; wr_en = 1; pop = 1; push = 1; rx_rd_en = 1; wr_data = 16'hBEEF; D_push = 16'h77EE;
        tick();
        check_zero("midreset");
        reset = 0; wr_en = 0; pop = 0; push = 0; rx_rd_en = 0;
        tx_q.delete(); rx_q.delete(); m_txd = 0; m_rxd = 0; m_mis = 0;
        tick();
        check_zero("postreset");
        tx_step(1, 16'h0AAA, 0);
        check("D_pop_after_reset", D_pop, 16'h0AAA);
        tx_step(0, 16'h0, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
